// File: rtl/wave_seq_pkg.sv
// Shared constants for the waveform sequencer: state encoding, mode codes
// and default widths.
package wave_seq_pkg;

  localparam int PHASE_W_DEF = 3;
  localparam int DIV_W_DEF   = 8;
  localparam int REP_W_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_SAW    = 2'b00;
  localparam logic [1:0] MODE_RAMPDN = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;
  localparam logic [1:0] MODE_SQR    = 2'b11;

endpackage

// File: rtl/phase_counter.sv
// W-bit phase counter with synchronous clear and enable. Exposes the next
// count so the owner can register a sample that lines up with the phase,
// and a wrap flag for the step that rolls max back to zero.
module phase_counter #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt,
  output logic         wrap
);

  logic [W-1:0] count_q, count_d;

  // clear beats enable; otherwise count up by one on enable
  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + W'(1);
  end

  // count register
  always_ff @(posedge clock) begin
    count_q <= count_d;
  end

  assign count     = count_q;
  assign count_nxt = count_d;
  assign wrap      = en && (count_q == '1);

endmodule

// File: rtl/waveform_sequencer.sv
// Waveform sequencer: runs the phase counter through whole 8-step periods,
// each phase lasting divider+1 cycles, and maps phase to a waveform sample.
// Optional feature macro: WAVE_SEQ_PAUSE_EN adds a pause input that freezes
// the run while high.
module waveform_sequencer
  import wave_seq_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int REP_W   = REP_W_DEF
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   divider,
  input  logic [REP_W-1:0]   repeat_cnt,
`ifdef WAVE_SEQ_PAUSE_EN
  input  logic               pause,
`endif
  output logic               busy,
  output logic               done,
  output logic [PHASE_W-1:0] phase,
  output logic [PHASE_W-1:0] wave_out
);

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [DIV_W-1:0]   div_q, div_d, presc_q, presc_d;
  logic [REP_W-1:0]   rep_q, rep_d, per_q, per_d;
  logic [PHASE_W-1:0] wave_q, wave_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic               paused, start_acc, abort_run, step, pc_clr, wrap;
  logic [PHASE_W-1:0] phase_nxt;

`ifdef WAVE_SEQ_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  // abort wins over start in IDLE and over a completing step in RUN
  assign start_acc = (state_q == ST_IDLE) && start && !abort;
  assign abort_run = (state_q == ST_RUN) && abort;
  assign step      = (state_q == ST_RUN) && !abort && !paused && (presc_q == div_q);
  assign pc_clr    = clear || start_acc || abort_run;

  phase_counter #(.W(PHASE_W)) u_phase (
    .clock     (clock),
    .clr       (pc_clr),
    .en        (step),
    .count     (phase),
    .count_nxt (phase_nxt),
    .wrap      (wrap)
  );

  function automatic logic [PHASE_W-1:0] wmap(input logic [1:0] m,
                                              input logic [PHASE_W-1:0] p);
    logic [PHASE_W-1:0] dbl;
    dbl = {p[PHASE_W-2:0], 1'b0};
    case (m)
      MODE_SAW:    wmap = p;
      MODE_RAMPDN: wmap = ~p;
      MODE_TRI:    wmap = p[PHASE_W-1] ? ~dbl : dbl;
      default:     wmap = p[PHASE_W-1] ? '0 : '1;
    endcase
  endfunction

  // next-state: FSM, prescaler, period count and registered outputs
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    div_d   = div_q;
    rep_d   = rep_q;
    presc_d = presc_q;
    per_d   = per_q;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d = ST_RUN;
          mode_d  = mode;
          div_d   = divider;
          rep_d   = repeat_cnt;
          presc_d = '0;
          per_d   = '0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!paused) begin
          if (step) begin
            presc_d = '0;
            if (wrap) begin
              per_d = per_q + REP_W'(1);
              // repeat_cnt==0 runs forever; per_q is then free to wrap
              if ((rep_q != '0) && (per_d == rep_q)) state_d = ST_DONE;
            end
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    // sample is registered alongside the phase so both change together
    wave_d = (state_d == ST_RUN) ? wmap(mode_d, phase_nxt) : '0;
  end

  // state registers with synchronous active-high clear
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      div_q   <= '0;
      rep_q   <= '0;
      presc_q <= '0;
      per_q   <= '0;
      wave_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      rep_q   <= rep_d;
      presc_q <= presc_d;
      per_q   <= per_d;
      wave_q  <= wave_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign wave_out = wave_q;

endmodule

// File: tb/tb_waveform_sequencer.sv
// Bench for waveform_sequencer: a run-time model (elapsed active cycles ->
// phase/sample) checked every cycle, plus directed literal expectations.
module tb_waveform_sequencer;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] divider = 8'd0;
  logic [3:0] repeat_cnt = 4'd0;
`ifdef WAVE_SEQ_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic       busy, done;
  logic [2:0] phase, wave_out;

  int compared = 0;
  int mismatched = 0;
  int dones = 0;

  always #5 clock = ~clock;

  waveform_sequencer dut (
    .clock      (clock),
    .clear      (clear),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .divider    (divider),
    .repeat_cnt (repeat_cnt),
`ifdef WAVE_SEQ_PAUSE_EN
    .pause      (pause),
`endif
    .busy       (busy),
    .done       (done),
    .phase      (phase),
    .wave_out   (wave_out)
  );

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_map(input int md, input int p);
    int tri_t[8] = '{0, 2, 4, 6, 7, 5, 3, 1};
    case (md)
      0:       return p;
      1:       return 7 - p;
      2:       return tri_t[p];
      default: return (p < 4) ? 7 : 0;
    endcase
  endfunction

  // Model: a run is "n active cycles elapsed"; it lasts 8*(div+1)*rep
  bit m_run, m_done;
  int n, m_mode, m_div, m_rep;

  initial begin
    bit p;
    int mph;
    m_run = 0; m_done = 0; n = 0; m_mode = 0; m_div = 0; m_rep = 0;
    forever begin
      @(posedge clock);
`ifdef WAVE_SEQ_PAUSE_EN
      p = pause;
`else
      p = 1'b0;
`endif
      if (clear) begin
        m_run = 0; m_done = 0; n = 0;
      end else if (m_done) begin
        m_done = 0;
      end else if (m_run) begin
        if (abort) m_run = 0;
        else if (!p) begin
          n++;
          if (m_rep != 0 && n == 8 * (m_div + 1) * m_rep) begin
            m_run = 0; m_done = 1;
          end
        end
      end else if (start && !abort) begin
        m_run = 1; n = 0;
        m_mode = int'(mode); m_div = int'(divider); m_rep = int'(repeat_cnt);
      end
      #1;
      mph = m_run ? (n / (m_div + 1)) % 8 : 0;
      chk("model_busy",  int'(busy),     int'(m_run | m_done));
      chk("model_done",  int'(done),     int'(m_done));
      chk("model_phase", int'(phase),    mph);
      chk("model_wave",  int'(wave_out), m_run ? exp_map(m_mode, mph) : 0);
      if (done) dones++;
    end
  end

  task automatic pulse_start(input int md, input int d, input int r);
    mode = 2'(md); divider = 8'(d); repeat_cnt = 4'(r);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 60) begin
      @(negedge clock);
      t++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int tri_t[8] = '{0, 2, 4, 6, 7, 5, 3, 1};
    int d0, t, rc;
    // reset held for two edges
    repeat (2) @(negedge clock);
    clear = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_wave", int'(wave_out), 0);

    // sawtooth, two periods
    d0 = dones;
    pulse_start(0, 0, 2);
    for (int i = 0; i < 16; i++) begin
      chk("saw", int'(wave_out), i % 8);
      @(negedge clock);
    end
    chk("saw_done", int'(done), 1);
    chk("saw_done_cnt", dones, d0 + 1);
    @(negedge clock);
    chk("saw_busy_low", int'(busy), 0);
    chk("saw_done_low", int'(done), 0);

    // triangle, divider 2
    pulse_start(2, 2, 1);
    for (int i = 0; i < 24; i++) begin
      chk("tri", int'(wave_out), tri_t[i / 3]);
      @(negedge clock);
    end
    chk("tri_done", int'(done), 1);
    @(negedge clock);

    // continuous square, then abort at phase 5
    pulse_start(3, 0, 0);
    for (int i = 0; i < 20; i++) begin
      chk("sqr", int'(wave_out), ((i % 8) < 4) ? 7 : 0);
      @(negedge clock);
    end
    t = 0;
    while (phase != 3'd5 && t < 16) begin
      @(negedge clock);
      t++;
    end
    chk("sqr_reach5", int'(phase), 5);
    d0 = dones;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_wave", int'(wave_out), 0);
    chk("abort_phase", int'(phase), 0);
    @(negedge clock);
    chk("abort_nodone", dones, d0);

    // start + abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    chk("idle_start_abort", int'(busy), 0);

    // start during RUN must not change the latched mode
    pulse_start(1, 0, 1);
    @(negedge clock);
    mode = 2'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("ramp_hold", int'(wave_out), 5);
    wait_idle();

    // abort on the completing step
    pulse_start(0, 0, 1);
    repeat (7) @(negedge clock);
    chk("last_phase", int'(phase), 7);
    d0 = dones;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("last_abort_busy", int'(busy), 0);
    chk("last_abort_wave", int'(wave_out), 0);
    repeat (2) @(negedge clock);
    chk("last_abort_nodone", dones, d0);

    // clear mid-run
    d0 = dones;
    pulse_start(2, 1, 3);
    repeat (5) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clr_busy", int'(busy), 0);
    chk("clr_done", int'(done), 0);
    chk("clr_phase", int'(phase), 0);
    chk("clr_wave", int'(wave_out), 0);
    repeat (2) @(negedge clock);
    chk("clr_nodone", dones, d0);

`ifdef WAVE_SEQ_PAUSE_EN
    // pause 5 cycles at phase 3: run grows from 8 to 13 cycles
    pulse_start(0, 0, 1);
    repeat (3) @(negedge clock);
    chk("pause_at3", int'(phase), 3);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("pause_phase", int'(phase), 3);
      chk("pause_wave", int'(wave_out), 3);
    end
    pause = 1'b0;
    rc = 9;
    t = 0;
    @(negedge clock);
    while (busy && !done && t < 40) begin
      rc++;
      t++;
      @(negedge clock);
    end
    chk("pause_len", rc, 13);
    wait_idle();
`else
    rc = 0;
`endif

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
